pixel_buffer: RTL and testbench

PIXEL_BUFFER -- requirements
Module: pixel_buffer

---
 rtl/pixel_buffer.sv | 113 +++++++++++
 tb/tb_pixel_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_buffer.sv
// Pixel buffer: 64 x 12-bit FIFO, filled 8 pixels per edge from nibble-packed
// R/G/B words and drained one pixel per edge with first-word-fall-through.
module pixel_buffer (
    input  logic        clk,
    input  logic        rst_,
    input  logic [31:0] r_data,
    input  logic [31:0] g_data,
    input  logic [31:0] b_data,
    input  logic        r_rts,
    input  logic        g_rts,
    input  logic        b_rts,
    output logic        in_rtr,
    output logic [11:0] current_pixel,
    output logic        out_rts,
    input  logic        out_rtr,
    output logic [5:0]  wr_addr,
    output logic [5:0]  rd_addr,
    output logic [11:0] d0,
    output logic [11:0] d1,
    output logic [11:0] d2,
    output logic [11:0] d3,
    output logic [11:0] d4,
    output logic [11:0] d5,
    output logic [11:0] d6,
    output logic [11:0] d7,
    output logic [11:0] d8,
    output logic [11:0] d9,
    output logic [11:0] d10,
    output logic [11:0] d11,
    output logic [11:0] d12,
    output logic [11:0] d13,
    output logic [11:0] d14,
    output logic [11:0] d15
);

    localparam int DEPTH     = 64;
    localparam int WORD_PIX  = 8;
    localparam logic [6:0] RTR_LIMIT = 7'd56;

    logic [11:0] mem [DEPTH];
    logic [6:0]  count;
    logic [6:0]  count_next;
    logic        write_en;
    logic        read_en;

    // A 56-entry ceiling guarantees a full word fits even with no pop this edge.
    assign in_rtr   = (count <= RTR_LIMIT);
    assign out_rts  = (count != 7'd0);
    assign write_en = r_rts & g_rts & b_rts & in_rtr;
    assign read_en  = out_rts & out_rtr;

    assign current_pixel = mem[rd_addr];

    // NOTE: always_comb assigns a default first so no path leaves count_next unassigned (no latch).
    always_comb begin
        count_next = count;
        unique case ({write_en, read_en})
            2'b10:   count_next = count + 7'd8;
            2'b01:   count_next = count - 7'd1;
            2'b11:   count_next = count + 7'd7;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_addr <= '0;
            rd_addr <= '0;
            count   <= '0;
        end else begin
            count <= count_next;
            if (write_en) begin
                wr_addr <= wr_addr + 6'd8;
            end
            if (read_en) begin
                rd_addr <= rd_addr + 6'd1;
            end
        end
    end

    // NOTE: the storage array is reset too, because reset must visibly clear every entry.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en) begin
            // wr_addr is always 8-aligned, so the slot index is just its upper bits plus k.
            for (int k = 0; k < WORD_PIX; k++) begin
                mem[{wr_addr[5:3], 3'(k)}] <= {r_data[4*k +: 4], g_data[4*k +: 4], b_data[4*k +: 4]};
            end
        end
    end

    assign d0  = mem[0];
    assign d1  = mem[1];
    assign d2  = mem[2];
    assign d3  = mem[3];
    assign d4  = mem[4];
    assign d5  = mem[5];
    assign d6  = mem[6];
    assign d7  = mem[7];
    assign d8  = mem[8];
    assign d9  = mem[9];
    assign d10 = mem[10];
    assign d11 = mem[11];
    assign d12 = mem[12];
    assign d13 = mem[13];
    assign d14 = mem[14];
    assign d15 = mem[15];

endmodule

// File: tb/tb_pixel_buffer.sv
// Directed self-checking bench for pixel_buffer: reset, fill, drain, full,
// partial handshake, simultaneous write/pop and asynchronous mid-cycle reset.
module tb_pixel_buffer;

    logic        clk = 1'b0;
    logic        rst_;
    logic [31:0] r_data, g_data, b_data;
    logic        r_rts, g_rts, b_rts;
    logic        in_rtr;
    logic [11:0] current_pixel;
    logic        out_rts;
    logic        out_rtr;
    logic [5:0]  wr_addr, rd_addr;
    logic [11:0] d [16];

    int n_checks = 0;
    int n_fail   = 0;

    pixel_buffer dut (
        .clk(clk), .rst_(rst_),
        .r_data(r_data), .g_data(g_data), .b_data(b_data),
        .r_rts(r_rts), .g_rts(g_rts), .b_rts(b_rts),
        .in_rtr(in_rtr), .current_pixel(current_pixel),
        .out_rts(out_rts), .out_rtr(out_rtr),
        .wr_addr(wr_addr), .rd_addr(rd_addr),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .d8(d[8]), .d9(d[9]), .d10(d[10]), .d11(d[11]),
        .d12(d[12]), .d13(d[13]), .d14(d[14]), .d15(d[15])
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r_rts = 1'b0; g_rts = 1'b0; b_rts = 1'b0;
        r_data = '0; g_data = '0; b_data = '0;
        out_rtr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
    endtask

    task automatic send(input logic [31:0] w);
        r_data = w; g_data = w; b_data = w;
        r_rts = 1'b1; g_rts = 1'b1; b_rts = 1'b1;
        tick();
        r_rts = 1'b0; g_rts = 1'b0; b_rts = 1'b0;
    endtask

    task automatic pop_n(input int n);
        out_rtr = 1'b1;
        repeat (n) tick();
        out_rtr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ = 1'b0;
        #2;
        n_checks++;
        if (in_rtr !== 1'b1) begin n_fail++; $display("FAIL reset_in_rtr got=%b exp=1", in_rtr); end
        n_checks++;
        if (out_rts !== 1'b0) begin n_fail++; $display("FAIL reset_out_rts got=%b exp=0", out_rts); end
        n_checks++;
        if (current_pixel !== 12'h000) begin n_fail++; $display("FAIL reset_pixel got=%h exp=000", current_pixel); end
        n_checks++;
        if (wr_addr !== 6'd0 || rd_addr !== 6'd0) begin
            n_fail++; $display("FAIL reset_ptrs got wr=%0d rd=%0d exp 0/0", wr_addr, rd_addr);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (d[i] !== 12'h000) begin n_fail++; $display("FAIL reset_d%0d got=%h exp=000", i, d[i]); end
        end
        tick();
        rst_ = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        send(32'h7654_3210);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (d[k] !== 12'(k * 12'h111)) begin
                n_fail++; $display("FAIL single_d%0d got=%h exp=%h", k, d[k], 12'(k * 12'h111));
            end
        end
        n_checks++;
        if (wr_addr !== 6'd8) begin n_fail++; $display("FAIL single_wr_addr got=%0d exp=8", wr_addr); end
        n_checks++;
        if (out_rts !== 1'b1) begin n_fail++; $display("FAIL single_out_rts got=%b exp=1", out_rts); end
        n_checks++;
        if (current_pixel !== 12'h000) begin n_fail++; $display("FAIL single_pixel got=%h exp=000", current_pixel); end
    endtask

    // Continues from test_single_write: drain the 8 pixels in nibble order.
    task automatic test_drain();
        out_rtr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (current_pixel !== 12'(k * 12'h111) || out_rts !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_step%0d got pix=%h rts=%b exp pix=%h rts=1", k, current_pixel, out_rts, 12'(k * 12'h111));
            end
            tick();
        end
        out_rtr = 1'b0;
        n_checks++;
        if (out_rts !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", out_rts); end
        n_checks++;
        if (rd_addr !== 6'd8) begin n_fail++; $display("FAIL drain_rd_addr got=%0d exp=8", rd_addr); end
    endtask

    task automatic test_second_word();
        do_reset();
        send(32'h7654_3210);
        send(32'hFEDC_BA98);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (d[8 + k] !== 12'(12'h888 + k * 12'h111)) begin
                n_fail++; $display("FAIL second_d%0d got=%h exp=%h", 8 + k, d[8 + k], 12'(12'h888 + k * 12'h111));
            end
        end
        n_checks++;
        if (wr_addr !== 6'd16) begin n_fail++; $display("FAIL second_wr_addr got=%0d exp=16", wr_addr); end
    endtask

    // Six writes: two each of 76543210, FEDCBA98, 76543210 -> entries 8..15 hold the second 76543210.
    task automatic test_multi_write();
        do_reset();
        send(32'h7654_3210); send(32'h7654_3210);
        send(32'hFEDC_BA98); send(32'hFEDC_BA98);
        send(32'h7654_3210); send(32'h7654_3210);
        n_checks++;
        if (wr_addr !== 6'd48) begin n_fail++; $display("FAIL multi_wr_addr got=%0d exp=48", wr_addr); end
        n_checks++;
        if (dut.count !== 7'd48) begin n_fail++; $display("FAIL multi_count got=%0d exp=48", dut.count); end
        n_checks++;
        if (in_rtr !== 1'b1) begin n_fail++; $display("FAIL multi_in_rtr got=%b exp=1", in_rtr); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (d[8 + k] !== 12'(k * 12'h111)) begin
                n_fail++; $display("FAIL multi_d%0d got=%h exp=%h", 8 + k, d[8 + k], 12'(k * 12'h111));
            end
        end
    endtask

    // Continues from test_multi_write at count 48.
    task automatic test_full();
        send(32'h7654_3210);
        n_checks++;
        if (dut.count !== 7'd56 || in_rtr !== 1'b1) begin
            n_fail++; $display("FAIL full_56 got cnt=%0d rtr=%b exp 56/1", dut.count, in_rtr);
        end
        send(32'h7654_3210);
        n_checks++;
        if (dut.count !== 7'd64 || in_rtr !== 1'b0 || wr_addr !== 6'd0) begin
            n_fail++; $display("FAIL full_64 got cnt=%0d rtr=%b wr=%0d exp 64/0/0", dut.count, in_rtr, wr_addr);
        end
        // Held rts while full must not overwrite entry 0 or move wr_addr.
        send(32'hFEDC_BA98);
        n_checks++;
        if (wr_addr !== 6'd0 || d[0] !== 12'h000 || dut.count !== 7'd64) begin
            n_fail++; $display("FAIL full_ignore got wr=%0d d0=%h cnt=%0d exp 0/000/64", wr_addr, d[0], dut.count);
        end
        r_data = 32'hFEDC_BA98; g_data = 32'hFEDC_BA98; b_data = 32'hFEDC_BA98;
        r_rts = 1'b1; g_rts = 1'b1; b_rts = 1'b1;
        pop_n(1);
        r_rts = 1'b0; g_rts = 1'b0; b_rts = 1'b0;
        n_checks++;
        if (dut.count !== 7'd63 || in_rtr !== 1'b0 || rd_addr !== 6'd1 || wr_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL full_pop1 got cnt=%0d rtr=%b rd=%0d wr=%0d exp 63/0/1/0", dut.count, in_rtr, rd_addr, wr_addr);
        end
        pop_n(6);
        n_checks++;
        if (in_rtr !== 1'b0) begin n_fail++; $display("FAIL full_57_rtr got=%b exp=0", in_rtr); end
        pop_n(1);
        n_checks++;
        if (in_rtr !== 1'b1 || dut.count !== 7'd56) begin
            n_fail++; $display("FAIL full_56_rtr got rtr=%b cnt=%0d exp 1/56", in_rtr, dut.count);
        end
    endtask

    task automatic test_partial_rts();
        do_reset();
        r_data = 32'h7654_3210; g_data = 32'h7654_3210; b_data = 32'h7654_3210;
        r_rts = 1'b1; g_rts = 1'b1; b_rts = 1'b0;
        tick();
        r_rts = 1'b0; g_rts = 1'b0;
        n_checks++;
        if (wr_addr !== 6'd0 || rd_addr !== 6'd0 || out_rts !== 1'b0) begin
            n_fail++; $display("FAIL partial_nowrite got wr=%0d rd=%0d rts=%b exp 0/0/0", wr_addr, rd_addr, out_rts);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(32'h7654_3210);
        pop_n(7);
        n_checks++;
        if (dut.count !== 7'd1 || current_pixel !== 12'h777) begin
            n_fail++; $display("FAIL b2b_pre got cnt=%0d pix=%h exp 1/777", dut.count, current_pixel);
        end
        r_data = 32'hFEDC_BA98; g_data = 32'hFEDC_BA98; b_data = 32'hFEDC_BA98;
        r_rts = 1'b1; g_rts = 1'b1; b_rts = 1'b1;
        out_rtr = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (dut.count !== 7'd8 || wr_addr !== 6'd16 || rd_addr !== 6'd8) begin
            n_fail++;
            $display("FAIL b2b_ptrs got cnt=%0d wr=%0d rd=%0d exp 8/16/8", dut.count, wr_addr, rd_addr);
        end
        n_checks++;
        if (current_pixel !== 12'h888) begin n_fail++; $display("FAIL b2b_pixel got=%h exp=888", current_pixel); end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(32'h7654_3210); send(32'h7654_3210); send(32'h7654_3210);
        pop_n(4);
        n_checks++;
        if (dut.count !== 7'd20) begin n_fail++; $display("FAIL async_pre got cnt=%0d exp=20", dut.count); end
        rst_ = 1'b0;
        #2;
        n_checks++;
        if (out_rts !== 1'b0 || in_rtr !== 1'b1 || wr_addr !== 6'd0 || rd_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL async_clear got rts=%b rtr=%b wr=%0d rd=%0d exp 0/1/0/0", out_rts, in_rtr, wr_addr, rd_addr);
        end
        n_checks++;
        if (d[0] !== 12'h000 || d[9] !== 12'h000 || current_pixel !== 12'h000) begin
            n_fail++; $display("FAIL async_mem got d0=%h d9=%h pix=%h exp 000", d[0], d[9], current_pixel);
        end
        tick();
        rst_ = 1'b1;
        send(32'hFEDC_BA98);
        n_checks++;
        if (wr_addr !== 6'd8 || d[0] !== 12'h888 || out_rts !== 1'b1) begin
            n_fail++; $display("FAIL async_resume got wr=%0d d0=%h rts=%b exp 8/888/1", wr_addr, d[0], out_rts);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_drain();
        test_second_word();
        test_multi_write();
        test_full();
        test_partial_rts();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
